// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the 5-stage pipe.
// Produces per-stage stall/flush for if_reg, id_reg, ex_reg and mem_reg.
// It covers load-use bubbles, branch squash, MDU waits, memory wait states
// and trap redirection.
module pipe_ctrl #(
    parameter int GPR_ADDR_WIDTH = 5,
    parameter int MDU_TIMEOUT    = 64,
    parameter int CNT_WIDTH      = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_en,
    input  logic [GPR_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic                      id_rs1_used,
    input  logic [GPR_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_rs2_used,
    input  logic                      ex_en,
    input  logic                      ex_is_load,
    input  logic                      ex_gpr_we_,
    input  logic [GPR_ADDR_WIDTH-1:0] ex_dst_addr,
    input  logic                      br_taken,
    input  logic                      mdu_start,
    input  logic                      mdu_done,
    input  logic                      dmem_req,
    input  logic                      dmem_ack,
    input  logic                      trap_req,
    output logic                      if_stall,
    output logic                      id_stall,
    output logic                      ex_stall,
    output logic                      mem_stall,
    output logic                      if_flush,
    output logic                      id_flush,
    output logic                      ex_flush,
    output logic                      mem_flush,
    output logic                      trap_redirect,
    output logic                      mdu_kill,
    output logic                      ctrl_err
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MDU_WAIT   = 2'd1,
        MEM_WAIT   = 2'd2,
        TRAP_REDIR = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   trap_pend;
    logic [CNT_WIDTH-1:0]   wait_cnt;

    // Bit order for the per-stage vectors: 0=if, 1=id, 2=ex, 3=mem.
    logic [3:0]             stall_raw;
    logic [3:0]             flush_raw;
    logic [3:0]             stall_vec;
    logic [3:0]             flush_vec;

    logic                   kill_nxt;
    logic                   err_set;
    logic                   pend_set;
    logic                   pend_clr;
    logic                   cnt_clr;
    logic                   cnt_inc;
    logic                   load_use;
    logic                   mdu_timeout;

    assign load_use = id_en & ex_en & ex_is_load & ~ex_gpr_we_ &
                      (ex_dst_addr != '0) &
                      ((id_rs1_used & (id_rs1_addr == ex_dst_addr)) |
                       (id_rs2_used & (id_rs2_addr == ex_dst_addr)));

    assign mdu_timeout = (wait_cnt == CNT_WIDTH'(MDU_TIMEOUT - 1));

    // Next-state and raw stall/flush decode from the current state and inputs.
    always_comb begin
        state_nxt = state;
        stall_raw = '0;
        flush_raw = '0;
        kill_nxt  = 1'b0;
        err_set   = 1'b0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state)
            RUN: begin
                if (trap_req) begin
                    flush_raw = '1;
                    pend_clr  = 1'b1;
                    state_nxt = TRAP_REDIR;
                end else if (dmem_req && !dmem_ack) begin
                    stall_raw = '1;
                    state_nxt = MEM_WAIT;
                end else if (mdu_start) begin
                    stall_raw = 4'b0111;
                    flush_raw = 4'b1000;
                    cnt_clr   = 1'b1;
                    state_nxt = MDU_WAIT;
                end else if (br_taken) begin
                    flush_raw = 4'b0011;
                end else if (load_use) begin
                    stall_raw = 4'b0011;
                    flush_raw = 4'b0100;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    // A trap arriving on the ack cycle itself is treated as pending.
                    if (trap_pend || trap_req) begin
                        flush_raw = '1;
                        pend_clr  = 1'b1;
                        state_nxt = TRAP_REDIR;
                    end else begin
                        state_nxt = RUN;
                    end
                end else begin
                    stall_raw = '1;
                    pend_set  = trap_req;
                end
            end
            MDU_WAIT: begin
                if (mdu_done) begin
                    state_nxt = RUN;
                end else if (trap_req) begin
                    flush_raw = '1;
                    kill_nxt  = 1'b1;
                    pend_clr  = 1'b1;
                    state_nxt = TRAP_REDIR;
                end else begin
                    stall_raw = 4'b0111;
                    flush_raw = 4'b1000;
                    cnt_inc   = 1'b1;
                    if (mdu_timeout) begin
                        flush_raw = 4'b1100;
                        kill_nxt  = 1'b1;
                        err_set   = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            TRAP_REDIR: begin
                flush_raw = 4'b0011;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Flush overrides stall in the same stage; outputs forced low while in reset.
    always_comb begin
        flush_vec = flush_raw & {4{rst_n}};
        stall_vec = stall_raw & ~flush_raw & {4{rst_n}};
    end

    assign if_stall  = stall_vec[0];
    assign id_stall  = stall_vec[1];
    assign ex_stall  = stall_vec[2];
    assign mem_stall = stall_vec[3];
    assign if_flush  = flush_vec[0];
    assign id_flush  = flush_vec[1];
    assign ex_flush  = flush_vec[2];
    assign mem_flush = flush_vec[3];

    // FSM state, pending trap, MDU wait counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            trap_pend     <= 1'b0;
            wait_cnt      <= '0;
            trap_redirect <= 1'b0;
            mdu_kill      <= 1'b0;
            ctrl_err      <= 1'b0;
        end else begin
            state         <= state_nxt;
            trap_redirect <= (state_nxt == TRAP_REDIR);
            mdu_kill      <= kill_nxt;
            if (err_set) begin
                ctrl_err <= 1'b1;
            end
            if (pend_clr) begin
                trap_pend <= 1'b0;
            end else if (pend_set) begin
                trap_pend <= 1'b1;
            end
            if (cnt_clr) begin
                wait_cnt <= '0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized traffic for pipe_ctrl,
// checked against a rule-level behavioural model.
module tb_pipe_ctrl;

    localparam int TMO = 64;

    // Model modes
    localparam int M_RUN  = 0;
    localparam int M_MDU  = 1;
    localparam int M_MEM  = 2;
    localparam int M_TRAP = 3;

    logic       clk;
    logic       rst_n;
    logic       id_en;
    logic [4:0] id_rs1_addr;
    logic       id_rs1_used;
    logic [4:0] id_rs2_addr;
    logic       id_rs2_used;
    logic       ex_en;
    logic       ex_is_load;
    logic       ex_gpr_we_;
    logic [4:0] ex_dst_addr;
    logic       br_taken;
    logic       mdu_start;
    logic       mdu_done;
    logic       dmem_req;
    logic       dmem_ack;
    logic       trap_req;
    logic       if_stall, id_stall, ex_stall, mem_stall;
    logic       if_flush, id_flush, ex_flush, mem_flush;
    logic       trap_redirect;
    logic       mdu_kill;
    logic       ctrl_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int m_mode;
    int m_waited;
    bit m_pend;
    bit m_redir;
    bit m_kill;
    bit m_err;

    pipe_ctrl #(
        .GPR_ADDR_WIDTH (5),
        .MDU_TIMEOUT    (TMO),
        .CNT_WIDTH      (7)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_en         (id_en),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_addr   (id_rs2_addr),
        .id_rs2_used   (id_rs2_used),
        .ex_en         (ex_en),
        .ex_is_load    (ex_is_load),
        .ex_gpr_we_    (ex_gpr_we_),
        .ex_dst_addr   (ex_dst_addr),
        .br_taken      (br_taken),
        .mdu_start     (mdu_start),
        .mdu_done      (mdu_done),
        .dmem_req      (dmem_req),
        .dmem_ack      (dmem_ack),
        .trap_req      (trap_req),
        .if_stall      (if_stall),
        .id_stall      (id_stall),
        .ex_stall      (ex_stall),
        .mem_stall     (mem_stall),
        .if_flush      (if_flush),
        .id_flush      (id_flush),
        .ex_flush      (ex_flush),
        .mem_flush     (mem_flush),
        .trap_redirect (trap_redirect),
        .mdu_kill      (mdu_kill),
        .ctrl_err      (ctrl_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pipe_vec();
        return {if_stall, id_stall, ex_stall, mem_stall,
                if_flush, id_flush, ex_flush, mem_flush};
    endfunction

    task automatic idle();
        id_en = 0; id_rs1_addr = 0; id_rs1_used = 0; id_rs2_addr = 0; id_rs2_used = 0;
        ex_en = 0; ex_is_load = 0; ex_gpr_we_ = 1; ex_dst_addr = 0;
        br_taken = 0; mdu_start = 0; mdu_done = 0;
        dmem_req = 0; dmem_ack = 0; trap_req = 0;
    endtask

    task automatic model_reset();
        m_mode = M_RUN; m_waited = 0; m_pend = 0;
        m_redir = 0; m_kill = 0; m_err = 0;
    endtask

    // One clock of stimulus: inputs already driven by the caller.
    task automatic step(input string tag);
        bit [3:0] s, f;   // [3]=if [2]=id [1]=ex [0]=mem
        int  nmode, nwaited;
        bit  npend, nkill, nerr, hazard;
        @(negedge clk);
        #1;
        s = 0; f = 0;
        nmode = m_mode; nwaited = m_waited; npend = m_pend;
        nkill = 0; nerr = m_err;
        hazard = id_en && ex_en && ex_is_load && !ex_gpr_we_ && ex_dst_addr != 0 &&
                 ((id_rs1_used && id_rs1_addr == ex_dst_addr) ||
                  (id_rs2_used && id_rs2_addr == ex_dst_addr));
        case (m_mode)
            M_RUN: begin
                if (trap_req) begin
                    f = 4'b1111; nmode = M_TRAP;
                end else if (dmem_req && !dmem_ack) begin
                    s = 4'b1111; nmode = M_MEM;
                end else if (mdu_start) begin
                    s = 4'b1110; f = 4'b0001; nwaited = 0; nmode = M_MDU;
                end else if (br_taken) begin
                    f = 4'b1100;
                end else if (hazard) begin
                    s = 4'b1100; f = 4'b0010;
                end
            end
            M_MEM: begin
                if (dmem_ack) begin
                    if (m_pend || trap_req) begin
                        f = 4'b1111; nmode = M_TRAP;
                    end else begin
                        nmode = M_RUN;
                    end
                end else begin
                    s = 4'b1111;
                    if (trap_req) npend = 1;
                end
            end
            M_MDU: begin
                if (mdu_done) begin
                    nmode = M_RUN;
                end else if (trap_req) begin
                    f = 4'b1111; nkill = 1; nmode = M_TRAP;
                end else begin
                    s = 4'b1110; f = 4'b0001;
                    if (m_waited + 1 >= TMO) begin
                        f = 4'b0011; nkill = 1; nerr = 1; nmode = M_RUN;
                    end else begin
                        nwaited = m_waited + 1;
                    end
                end
            end
            default: begin
                f = 4'b1100; nmode = M_RUN;
            end
        endcase
        if (nmode == M_TRAP) npend = 0;
        check({tag, "_pipe"}, {24'd0, pipe_vec()}, {24'd0, s & ~f, f});
        check({tag, "_redir"}, {31'd0, trap_redirect}, {31'd0, m_redir});
        check({tag, "_kill"}, {31'd0, mdu_kill}, {31'd0, m_kill});
        check({tag, "_err"}, {31'd0, ctrl_err}, {31'd0, m_err});
        @(posedge clk);
        #1;
        m_mode = nmode; m_waited = nwaited; m_pend = npend;
        m_kill = nkill; m_err = nerr; m_redir = (nmode == M_TRAP);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pipe"}, {24'd0, pipe_vec()}, 32'd0);
        check({tag, "_redir"}, {31'd0, trap_redirect}, 32'd0);
        check({tag, "_kill"}, {31'd0, mdu_kill}, 32'd0);
        check({tag, "_err"}, {31'd0, ctrl_err}, 32'd0);
    endtask

    task automatic set_load_use(input logic [4:0] dst, input logic we_);
        idle();
        ex_en = 1; ex_is_load = 1; ex_gpr_we_ = we_; ex_dst_addr = dst;
        id_en = 1; id_rs2_used = 1; id_rs2_addr = dst; id_rs1_used = 1; id_rs1_addr = 5'd7;
    endtask

    initial begin
        model_reset();
        // Reset with busy inputs: everything must read zero.
        rst_n = 0;
        idle();
        trap_req = 1; br_taken = 1; dmem_req = 1; mdu_start = 1;
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset_hold");
        @(negedge clk);
        rst_n = 1;
        idle();
        step("idle");

        // Load-use on x5 through rs2: one bubble.
        set_load_use(5'd5, 1'b0);
        step("loaduse");
        check("loaduse_ifstall", {31'd0, if_stall}, 32'd1);
        idle();
        step("after_loaduse");
        // Same pattern targeting x0, and with write disabled: no stall.
        set_load_use(5'd0, 1'b0);
        step("loaduse_x0");
        set_load_use(5'd5, 1'b1);
        step("loaduse_nowe");

        // Branch squash for one cycle.
        idle(); br_taken = 1;
        step("branch");
        idle();
        step("after_branch");

        // MDU op completing after 10 wait cycles.
        mdu_start = 1;
        step("mdu_start");
        mdu_start = 0;
        for (int i = 0; i < 10; i++) step("mdu_wait");
        mdu_done = 1;
        step("mdu_done");
        mdu_done = 0;
        step("mdu_after");

        // Memory wait, trap during the wait, ack after 3 cycles.
        dmem_req = 1;
        step("mem_req");
        trap_req = 1;
        step("mem_wait_trap");
        trap_req = 0;
        step("mem_wait");
        dmem_ack = 1;
        step("mem_ack");
        idle();
        step("trap_redir");
        step("after_trap");

        // MDU timeout: no done for the full window.
        mdu_start = 1;
        step("tmo_start");
        mdu_start = 0;
        for (int i = 0; i < TMO; i++) step("tmo_wait");
        step("tmo_kill");
        check("tmo_err_sticky", {31'd0, ctrl_err}, 32'd1);
        step("tmo_after");

        // Trap while waiting on the MDU.
        mdu_start = 1;
        step("mdutrap_start");
        mdu_start = 0;
        step("mdutrap_wait");
        trap_req = 1;
        step("mdutrap_trap");
        trap_req = 0;
        step("mdutrap_redir");
        step("mdutrap_after");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            id_en       = ($urandom % 4) != 0;
            id_rs1_addr = 5'($urandom % 4);
            id_rs1_used = 1'($urandom % 2);
            id_rs2_addr = 5'($urandom % 4);
            id_rs2_used = 1'($urandom % 2);
            ex_en       = ($urandom % 4) != 0;
            ex_is_load  = 1'($urandom % 2);
            ex_gpr_we_  = ($urandom % 4) == 0;
            ex_dst_addr = 5'($urandom % 4);
            br_taken    = ($urandom % 6) == 0;
            mdu_start   = ($urandom % 10) == 0;
            mdu_done    = ($urandom % 12) == 0;
            dmem_req    = ($urandom % 4) == 0;
            dmem_ack    = ($urandom % 3) == 0;
            trap_req    = ($urandom % 20) == 0;
            step("rand");
        end

        // Force a known sticky error, then reset in the middle of an MDU wait.
        idle();
        step("pre_rst_idle");
        step("pre_rst_idle2");
        mdu_start = 1;
        step("rstmdu_start");
        mdu_start = 0;
        for (int i = 0; i < 3; i++) step("rstmdu_wait");
        trap_req = 1; br_taken = 1; dmem_req = 1;
        rst_n = 0;
        #1;
        check_all_zero("rst_mid_mdu");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        idle();
        step("post_rst");
        br_taken = 1;
        step("post_rst_branch");
        idle();
        step("post_rst_idle");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
